sound_gen: RTL and testbench

SOUND_GEN -- requirements
Module: sound_gen

---
 rtl/sound_gen.sv | 152 +++++++++++++++
 tb/tb_sound_gen.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sound_gen.sv
// Tone generator: plays one of four square-wave tones for a fixed number of ticks.
// Retrigger restarts the tone; completion emits a one-cycle done pulse.
module sound_gen #(
    parameter int HP0      = 56818,
    parameter int HP1      = 113636,
    parameter int HP2      = 75838,
    parameter int HP3      = 28409,
    parameter int DUR0     = 100,
    parameter int DUR1     = 100,
    parameter int DUR2     = 250,
    parameter int DUR3     = 500,
    parameter int TICK_DIV = 50000,
    parameter int HP_W     = 18,
    parameter int DUR_W    = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trig,
    input  logic [1:0] sel,
    input  logic       mute,
    output logic       speaker,
    output logic       busy,
    output logic       done
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_M1 = TICK_W'(TICK_DIV - 1);

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    state_t              state_r, state_s;
    logic [1:0]          sel_r, sel_s;
    logic [HP_W-1:0]     hp_cnt_r, hp_cnt_s;
    logic [TICK_W-1:0]   tick_cnt_r, tick_cnt_s;
    logic [DUR_W-1:0]    dur_cnt_r, dur_cnt_s;
    logic                tone_r, tone_s;
    logic                busy_r, busy_s;
    logic                done_r, done_s;

    function automatic logic [HP_W-1:0] hp_last(input logic [1:0] s);
        logic [HP_W-1:0] v;
        case (s)
            2'd0:    v = HP_W'(HP0 - 1);
            2'd1:    v = HP_W'(HP1 - 1);
            2'd2:    v = HP_W'(HP2 - 1);
            2'd3:    v = HP_W'(HP3 - 1);
            default: v = HP_W'(HP0 - 1);
        endcase
        return v;
    endfunction

    function automatic logic [DUR_W-1:0] dur_last(input logic [1:0] s);
        logic [DUR_W-1:0] v;
        case (s)
            2'd0:    v = DUR_W'(DUR0 - 1);
            2'd1:    v = DUR_W'(DUR1 - 1);
            2'd2:    v = DUR_W'(DUR2 - 1);
            2'd3:    v = DUR_W'(DUR3 - 1);
            default: v = DUR_W'(DUR0 - 1);
        endcase
        return v;
    endfunction

    // Next-state and next-value logic for the IDLE/PLAY machine and its counters.
    always_comb begin
        state_s    = state_r;
        sel_s      = sel_r;
        hp_cnt_s   = HP_W'(1'b0);
        tick_cnt_s = TICK_W'(1'b0);
        dur_cnt_s  = DUR_W'(1'b0);
        tone_s     = 1'b0;
        busy_s     = 1'b0;
        done_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (trig) begin
                    sel_s   = sel;
                    state_s = PLAY;
                    busy_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            PLAY: begin
                busy_s = 1'b1;
                if (trig) begin
                    // Retrigger wins over a coincident natural completion.
                    sel_s   = sel;
                    state_s = PLAY;
                end else begin
                    if (hp_cnt_r == hp_last(sel_r)) begin
                        hp_cnt_s = HP_W'(1'b0);
                        tone_s   = ~tone_r;
                    end else begin
                        hp_cnt_s = hp_cnt_r + HP_W'(1'b1);
                        tone_s   = tone_r;
                    end
                    if (tick_cnt_r == TICK_M1) begin
                        tick_cnt_s = TICK_W'(1'b0);
                        if (dur_cnt_r == dur_last(sel_r)) begin
                            state_s  = IDLE;
                            hp_cnt_s = HP_W'(1'b0);
                            tone_s   = 1'b0;
                            busy_s   = 1'b0;
                            done_s   = 1'b1;
                        end else begin
                            dur_cnt_s = dur_cnt_r + DUR_W'(1'b1);
                        end
                    end else begin
                        tick_cnt_s = tick_cnt_r + TICK_W'(1'b1);
                        dur_cnt_s  = dur_cnt_r;
                    end
                end
            end
            default: begin
                state_s = IDLE;
                sel_s   = 2'd0;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            sel_r      <= 2'd0;
            hp_cnt_r   <= HP_W'(1'b0);
            tick_cnt_r <= TICK_W'(1'b0);
            dur_cnt_r  <= DUR_W'(1'b0);
            tone_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            sel_r      <= sel_s;
            hp_cnt_r   <= hp_cnt_s;
            tick_cnt_r <= tick_cnt_s;
            dur_cnt_r  <= dur_cnt_s;
            tone_r     <= tone_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

    assign speaker = tone_r & ~mute;
    assign busy    = busy_r;
    assign done    = done_r;

endmodule

// File: tb/tb_sound_gen.sv
// Self-checking bench for sound_gen: directed scenarios plus randomized traffic,
// compared against a model that tracks elapsed cycles since the last trigger.
module tb_sound_gen;

    localparam int TD = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       trig;
    logic [1:0] sel;
    logic       mute;
    logic       speaker;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    // Reference model state: playing flag, selected tone, cycles since trigger.
    bit m_play;
    bit m_done;
    int m_sel;
    int m_t;

    sound_gen #(
        .HP0(4), .HP1(2), .HP2(3), .HP3(5),
        .DUR0(3), .DUR1(1), .DUR2(2), .DUR3(1),
        .TICK_DIV(TD), .HP_W(4), .DUR_W(3)
    ) dut (
        .clk(clk), .rst(rst), .trig(trig), .sel(sel), .mute(mute),
        .speaker(speaker), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic int hp_of(input int s);
        case (s)
            0:       return 4;
            1:       return 2;
            2:       return 3;
            default: return 5;
        endcase
    endfunction

    function automatic int dur_of(input int s);
        case (s)
            0:       return 3;
            1:       return 1;
            2:       return 2;
            default: return 1;
        endcase
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag);
        logic exp_spk;
        exp_spk = 1'b0;
        if (m_play && !mute && ((m_t / hp_of(m_sel)) % 2 == 1)) exp_spk = 1'b1;
        check({tag, ".busy"}, busy, m_play);
        check({tag, ".done"}, done, m_done);
        check({tag, ".speaker"}, speaker, exp_spk);
    endtask

    task automatic model_edge();
        m_done = 1'b0;
        if (trig) begin
            m_play = 1'b1;
            m_sel  = int'(sel);
            m_t    = 0;
        end else if (m_play) begin
            m_t++;
            if (m_t == dur_of(m_sel) * TD) begin
                m_play = 1'b0;
                m_done = 1'b1;
                m_t    = 0;
            end
        end
    endtask

    task automatic step(input string tag, input logic t, input logic [1:0] s, input logic m);
        trig = t;
        sel  = s;
        mute = m;
        @(posedge clk);
        model_edge();
        #1;
        check_outs(tag);
        trig = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        rst  = 1'b1;
        trig = 1'b1;
        #1;
        m_play = 1'b0;
        m_done = 1'b0;
        m_t    = 0;
        check_outs({tag, ".async"});
        @(posedge clk);
        #1;
        check_outs({tag, ".held"});
        rst  = 1'b0;
        trig = 1'b0;
    endtask

    int busy_cnt;
    int done_cnt;

    initial begin
        rst  = 1'b0;
        trig = 1'b0;
        sel  = 2'd0;
        mute = 1'b0;
        m_play = 1'b0;
        m_done = 1'b0;
        m_sel  = 0;
        m_t    = 0;
        #2;
        do_reset("init_rst");

        // Single tone: 30 busy cycles and exactly one done pulse.
        busy_cnt = 0;
        done_cnt = 0;
        step("single", 1'b1, 2'd0, 1'b0);
        if (busy) busy_cnt++;
        for (int i = 0; i < 35; i++) begin
            step("single", 1'b0, 2'($urandom_range(0, 3)), 1'b0);
            if (busy) busy_cnt++;
            if (done) done_cnt++;
        end
        check("single.busy_len", 1'(busy_cnt == 30), 1'b1);
        check("single.done_cnt", 1'(done_cnt == 1), 1'b1);

        // Retrigger with sel=1 at cycle 12.
        done_cnt = 0;
        step("retrig", 1'b1, 2'd0, 1'b0);
        for (int i = 1; i < 12; i++) step("retrig", 1'b0, 2'd2, 1'b0);
        step("retrig2", 1'b1, 2'd1, 1'b0);
        busy_cnt = 1;
        for (int i = 0; i < 15; i++) begin
            step("retrig2", 1'b0, 2'd3, 1'b0);
            if (busy) busy_cnt++;
            if (done) done_cnt++;
        end
        check("retrig.busy_len", 1'(busy_cnt == 10), 1'b1);
        check("retrig.done_cnt", 1'(done_cnt == 1), 1'b1);

        // Trigger on the completion edge of a sel=0 tone.
        step("coinc", 1'b1, 2'd0, 1'b0);
        for (int i = 1; i < 30; i++) step("coinc", 1'b0, 2'd0, 1'b0);
        step("coinc_edge", 1'b1, 2'd1, 1'b0);
        check("coinc.no_done", done, 1'b0);
        check("coinc.busy", busy, 1'b1);
        for (int i = 0; i < 12; i++) step("coinc_tail", 1'b0, 2'd0, 1'b0);

        // Muted tone keeps timing.
        busy_cnt = 0;
        done_cnt = 0;
        step("mute", 1'b1, 2'd0, 1'b1);
        if (busy) busy_cnt++;
        for (int i = 0; i < 33; i++) begin
            step("mute", 1'b0, 2'd0, 1'b1);
            if (busy) busy_cnt++;
            if (done) done_cnt++;
        end
        check("mute.busy_len", 1'(busy_cnt == 30), 1'b1);
        check("mute.done_cnt", 1'(done_cnt == 1), 1'b1);

        // Reset mid-tone, then a full tone afterwards.
        step("rst_mid", 1'b1, 2'd0, 1'b0);
        for (int i = 1; i < 15; i++) step("rst_mid", 1'b0, 2'd0, 1'b0);
        #2;
        do_reset("rst_mid");
        busy_cnt = 0;
        step("after_rst", 1'b1, 2'd0, 1'b0);
        if (busy) busy_cnt++;
        for (int i = 0; i < 32; i++) begin
            step("after_rst", 1'b0, 2'd0, 1'b0);
            if (busy) busy_cnt++;
        end
        check("after_rst.busy_len", 1'(busy_cnt == 30), 1'b1);

        // Idle stability with sel toggling.
        for (int i = 0; i < 100; i++) step("idle", 1'b0, 2'(i % 4), 1'($urandom_range(0, 1)));

        // Randomized traffic, including occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                #2;
                do_reset("rand_rst");
            end else begin
                step("rand", 1'($urandom_range(0, 24) == 0), 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 4) == 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
